// File: rtl/obi_nport_arbiter.sv
// N-to-1 OBI request arbiter (round-robin or fixed priority) with an in-order
// response-routing FIFO that steers each response back to the port that issued it.
module obi_nport_arbiter #(
    parameter int    NUM_PORTS       = 2,
    parameter int    ADDR_WIDTH      = 32,
    parameter int    DATA_WIDTH      = 32,
    parameter int    MAX_OUTSTANDING = 2,
    parameter string ARB_MODE        = "RR"
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_PORTS-1:0]                   m_req_i,
    output logic [NUM_PORTS-1:0]                   m_gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        m_addr_i,
    input  logic [NUM_PORTS-1:0]                   m_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]      m_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]        m_wdata_i,
    output logic [NUM_PORTS-1:0]                   m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  m_rdata_o,
    output logic                                   s_req_o,
    input  logic                                   s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_be_o,
    output logic [DATA_WIDTH-1:0]                  s_wdata_o,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam bit FIXED_MODE = (ARB_MODE == "FIXED");

    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      lock_idx_reg;
    logic                  lock_valid_reg;
    logic                  err_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [IDX_W-1:0]      fifo_mem [MAX_OUTSTANDING];

    logic [IDX_W-1:0]      arb_sel;
    logic [IDX_W-1:0]      sel;
    logic [IDX_W-1:0]      head;
    logic                  lock_hold;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  handshake;
    logic                  pop;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    // Search upward from the start point with wrap; fixed mode always starts at port 0.
    always_comb begin
        int   cand;
        logic found;
        arb_sel = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = FIXED_MODE ? k : int'(rr_ptr_reg) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!found && m_req_i[cand]) begin
                found   = 1'b1;
                arb_sel = IDX_W'(cand);
            end
        end
    end

    // A stalled address phase pins the selection until its port is granted or withdraws.
    assign lock_hold  = lock_valid_reg & m_req_i[lock_idx_reg];
    assign sel        = lock_hold ? lock_idx_reg : arb_sel;
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign s_req_o    = rst_ni & (|m_req_i) & ~fifo_full;
    assign handshake  = s_req_o & s_gnt_i;
    assign pop        = rst_ni & s_rvalid_i & ~fifo_empty;
    assign head       = fifo_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]   = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]     = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign wdata_arr[gi]  = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign m_gnt_o[gi]    = handshake & (sel == IDX_W'(gi));
            assign m_rvalid_o[gi] = pop & (head == IDX_W'(gi));
        end
    endgenerate

    assign s_addr_o      = addr_arr[sel];
    assign s_we_o        = m_we_i[sel];
    assign s_be_o        = be_arr[sel];
    assign s_wdata_o     = wdata_arr[sel];
    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = count_reg;
    assign err_o         = err_reg;

    // Storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (handshake) fifo_mem[wr_ptr_reg] <= sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg     <= '0;
            lock_idx_reg   <= '0;
            lock_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            if (handshake) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
                if (!FIXED_MODE)
                    rr_ptr_reg <= (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            end
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
            case ({handshake, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (handshake) begin
                lock_valid_reg <= 1'b0;
            end else if (s_req_o && !s_gnt_i) begin
                lock_valid_reg <= 1'b1;
                lock_idx_reg   <= sel;
            end else begin
                lock_valid_reg <= 1'b0;
            end
            if ((s_rvalid_i && fifo_empty) || (lock_valid_reg && !lock_hold))
                err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_nport_arbiter.sv
// Bench for obi_nport_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model; a second instance covers fixed priority.
module tb_obi_nport_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    m_req, m_gnt, m_we, m_rvalid;
    logic [N*AW-1:0] m_addr;
    logic [N*BW-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, s_rdata, s_wdata;
    logic            s_req, s_gnt, s_we, s_rvalid, err;
    logic [AW-1:0]   s_addr;
    logic [BW-1:0]   s_be;
    logic [1:0]      outstanding;

    logic [N-1:0]    f_req, f_gnt, f_rvalid;
    logic            f_s_gnt, f_s_rvalid, f_s_req, f_s_we, f_err;
    logic [DW-1:0]   f_rdata, f_wdata;
    logic [AW-1:0]   f_addr;
    logic [BW-1:0]   f_be;
    logic [1:0]      f_outstanding;

    obi_nport_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MO), .ARB_MODE("RR")) dut (
        .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_gnt_o(m_gnt),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .s_req_o(s_req), .s_gnt_i(s_gnt),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .outstanding_o(outstanding), .err_o(err));

    obi_nport_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(MO), .ARB_MODE("FIXED")) dut_fixed (
        .clk_i(clk), .rst_ni(rst_n), .m_req_i(f_req), .m_gnt_o(f_gnt),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_rvalid_o(f_rvalid), .m_rdata_o(f_rdata), .s_req_o(f_s_req), .s_gnt_i(f_s_gnt),
        .s_addr_o(f_addr), .s_we_o(f_s_we), .s_be_o(f_be), .s_wdata_o(f_wdata),
        .s_rvalid_i(f_s_rvalid), .s_rdata_i(s_rdata), .outstanding_o(f_outstanding), .err_o(f_err));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: grant order queue, round-robin pointer, pinned port, sticky error.
    int mdl_ptr;
    bit mdl_lock_v;
    int mdl_lock_idx;
    bit mdl_err;
    int q[$];
    int exp_sel;
    bit exp_sreq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_ptr = 0; mdl_lock_v = 0; mdl_lock_idx = 0; mdl_err = 0;
        q.delete();
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
        m_req = req; s_gnt = gnt; s_rvalid = rv; s_rdata = rd;
        m_addr  = {$urandom, $urandom, $urandom};
        m_wdata = {$urandom, $urandom, $urandom};
        m_be    = N*BW'($urandom);
        m_we    = N'($urandom);
    endtask

    // Evaluate the model's combinational view of this cycle and compare every output.
    task automatic drive_check(input string tag);
        logic [N-1:0] eg, er;
        #1;
        exp_sreq = (m_req != '0) && (q.size() < MO);
        if (mdl_lock_v && m_req[mdl_lock_idx]) begin
            exp_sel = mdl_lock_idx;
        end else begin
            exp_sel = 0;
            for (int k = N - 1; k >= 0; k--)
                if (m_req[(mdl_ptr + k) % N]) exp_sel = (mdl_ptr + k) % N;
        end
        eg = (exp_sreq && s_gnt) ? N'(1 << exp_sel) : '0;
        er = (s_rvalid && q.size() > 0) ? N'(1 << q[0]) : '0;
        check({tag, "_sreq"}, 64'(s_req), 64'(exp_sreq));
        check({tag, "_gnt"}, 64'(m_gnt), 64'(eg));
        check({tag, "_rvalid"}, 64'(m_rvalid), 64'(er));
        check({tag, "_outst"}, 64'(outstanding), 64'(q.size()));
        check({tag, "_err"}, 64'(err), 64'(mdl_err));
        check({tag, "_rdata"}, 64'(m_rdata), 64'(s_rdata));
        if (exp_sreq) begin
            check({tag, "_addr"}, 64'(s_addr), 64'(m_addr[exp_sel*AW +: AW]));
            check({tag, "_we"}, 64'(s_we), 64'(m_we[exp_sel]));
            check({tag, "_be"}, 64'(s_be), 64'(m_be[exp_sel*BW +: BW]));
            check({tag, "_wdata"}, 64'(s_wdata), 64'(m_wdata[exp_sel*DW +: DW]));
        end
        $display("[%0t] %s req=%b gnt_in=%b rv_in=%b -> s_req=%b m_gnt=%b m_rvalid=%b outst=%0d err=%b",
                 $time, tag, m_req, s_gnt, s_rvalid, s_req, m_gnt, m_rvalid, outstanding, err);
    endtask

    task automatic tick();
        bit hs;
        @(posedge clk);
        hs = exp_sreq && s_gnt;
        if (mdl_lock_v && !m_req[mdl_lock_idx]) mdl_err = 1;
        if (s_rvalid && q.size() == 0) mdl_err = 1;
        if (s_rvalid && q.size() > 0) void'(q.pop_front());
        if (hs) begin
            q.push_back(exp_sel);
            mdl_ptr = (exp_sel + 1) % N;
        end
        if (!hs && exp_sreq && !s_gnt) begin
            mdl_lock_v = 1; mdl_lock_idx = exp_sel;
        end else begin
            mdl_lock_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(3'b111, 1'b1, 1'b1, '0);
        #1;
        check("rst_sreq", 64'(s_req), 64'd0);
        check("rst_gnt", 64'(m_gnt), 64'd0);
        check("rst_rvalid", 64'(m_rvalid), 64'd0);
        check("rst_outst", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        $display("[%0t] reset s_req=%b m_gnt=%b m_rvalid=%b outst=%0d err=%b",
                 $time, s_req, m_gnt, m_rvalid, outstanding, err);
        @(negedge clk);
        set_in('0, 1'b0, 1'b0, '0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rq;
        rst_n = 1'b1;
        f_req = '0; f_s_gnt = 1'b0; f_s_rvalid = 1'b0;
        set_in('0, 1'b0, 1'b0, '0);
        model_reset();
        @(negedge clk);

        // Round-robin rotation with every port requesting
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in(3'b111, 1'b1, (k != 0), DW'($urandom));
            drive_check("rr_rot");
            check($sformatf("rr_rot_order%0d", k), 64'(m_gnt), 64'(3'b001 << (k % 3)));
            tick();
        end

        // Stalled address phase stays pinned to port 1
        do_reset();
        set_in(3'b010, 1'b0, 1'b0, '0); drive_check("lock_c1");
        check("lock_c1_gnt", 64'(m_gnt), 64'd0); tick();
        for (int k = 0; k < 2; k++) begin
            set_in(3'b011, 1'b0, 1'b0, '0); drive_check("lock_hold");
            check("lock_hold_addr", 64'(s_addr), 64'(m_addr[AW +: AW])); tick();
        end
        set_in(3'b011, 1'b1, 1'b0, '0); drive_check("lock_rel");
        check("lock_rel_gnt", 64'(m_gnt), 64'(3'b010)); tick();

        // Outstanding limit with no pop bypass
        do_reset();
        set_in(3'b011, 1'b1, 1'b0, '0); drive_check("full_g0"); tick();
        set_in(3'b011, 1'b1, 1'b0, '0); drive_check("full_g1"); tick();
        set_in(3'b011, 1'b1, 1'b0, '0); drive_check("full_hold");
        check("full_outst2", 64'(outstanding), 64'd2);
        check("full_sreq0", 64'(s_req), 64'd0); tick();
        set_in(3'b011, 1'b1, 1'b1, DW'($urandom)); drive_check("full_pop");
        check("full_pop_route", 64'(m_rvalid), 64'(3'b001));
        check("full_pop_nobypass", 64'(s_req), 64'd0); tick();
        set_in(3'b011, 1'b1, 1'b0, '0); drive_check("full_after");
        check("full_after_sreq", 64'(s_req), 64'd1); tick();

        // Response routing in grant order
        do_reset();
        set_in(3'b100, 1'b1, 1'b0, '0); drive_check("route_g2");
        check("route_g2_gnt", 64'(m_gnt), 64'(3'b100)); tick();
        set_in(3'b001, 1'b1, 1'b0, '0); drive_check("route_g0");
        check("route_g0_gnt", 64'(m_gnt), 64'(3'b001)); tick();
        set_in('0, 1'b0, 1'b1, 32'hA5A5A5A5); drive_check("route_r1");
        check("route_r1_rv", 64'(m_rvalid), 64'(3'b100));
        check("route_r1_data", 64'(m_rdata), 64'h0A5A5A5A5); tick();
        set_in('0, 1'b0, 1'b1, 32'h5A5A5A5A); drive_check("route_r2");
        check("route_r2_rv", 64'(m_rvalid), 64'(3'b001));
        check("route_r2_data", 64'(m_rdata), 64'h05A5A5A5A); tick();

        // Random protocol-clean traffic against the model
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rq = N'($urandom_range(0, 7));
            if (mdl_lock_v) rq[mdl_lock_idx] = 1'b1;
            set_in(rq, ($urandom_range(0, 9) < 7), (q.size() > 0) && ($urandom_range(0, 1) == 1),
                   DW'($urandom));
            drive_check("rand");
            tick();
        end

        // Locked port withdrawing its request is a protocol error
        do_reset();
        set_in(3'b010, 1'b0, 1'b0, '0); drive_check("drop_c1"); tick();
        set_in(3'b001, 1'b0, 1'b0, '0); drive_check("drop_c2"); tick();
        set_in('0, 1'b0, 1'b0, '0); drive_check("drop_c3");
        check("drop_err", 64'(err), 64'd1); tick();

        // Response with nothing outstanding
        do_reset();
        set_in('0, 1'b0, 1'b1, DW'($urandom)); drive_check("empty_rv");
        check("empty_rv_none", 64'(m_rvalid), 64'd0); tick();
        set_in('0, 1'b0, 1'b0, '0); drive_check("empty_after");
        check("empty_err_sticky", 64'(err), 64'd1); tick();

        // Reset mid-transaction discards the outstanding entry
        do_reset();
        set_in(3'b001, 1'b1, 1'b0, '0); drive_check("mid_g"); tick();
        do_reset();
        set_in('0, 1'b0, 1'b1, DW'($urandom)); drive_check("mid_rv");
        check("mid_rv_none", 64'(m_rvalid), 64'd0);
        check("mid_outst", 64'(outstanding), 64'd0); tick();
        set_in('0, 1'b0, 1'b0, '0); drive_check("mid_after");
        check("mid_err", 64'(err), 64'd1); tick();

        // Fixed priority: port 0 starves port 2
        do_reset();
        f_req = 3'b101; f_s_gnt = 1'b1; f_s_rvalid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("fixed_gnt%0d", k), 64'(f_gnt), 64'(3'b001));
            check($sformatf("fixed_addr%0d", k), 64'(f_addr), 64'(m_addr[0 +: AW]));
            $display("[%0t] fixed req=%b -> m_gnt=%b outst=%0d", $time, f_req, f_gnt, f_outstanding);
            @(posedge clk);
            @(negedge clk);
            f_s_rvalid = 1'b1;
        end
        #1;
        check("fixed_outst", 64'(f_outstanding), 64'd1);
        check("fixed_err", 64'(f_err), 64'd0);
        f_req = '0; f_s_gnt = 1'b0; f_s_rvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/obi_nport_arbiter.md
OBI_NPORT_ARBITER -- requirements
Module: obi_nport_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NUM_PORTS, default 2: number of upstream OBI masters, range 1..16.
- ADDR_WIDTH, default 32: address width.
- DATA_WIDTH, default 32: data width, a multiple of 8.
- MAX_OUTSTANDING, default 2: response-routing FIFO depth, range 1..8.
- ARB_MODE, default "RR": "RR" selects round-robin; "FIXED" selects fixed priority with the lowest index winning.

REQ-002 The block SHALL have one clock and an asynchronous active-low reset; ports are listed as name, direction, width, meaning:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- m_req_i, in, NUM_PORTS: per-port request.
- m_gnt_o, out, NUM_PORTS: per-port grant.
- m_addr_i, in, NUM_PORTS*ADDR_WIDTH: per-port address, port i at slice i.
- m_we_i, in, NUM_PORTS: per-port write enable.
- m_be_i, in, NUM_PORTS*DATA_WIDTH/8: per-port byte enables.
- m_wdata_i, in, NUM_PORTS*DATA_WIDTH: per-port write data.
- m_rvalid_o, out, NUM_PORTS: per-port response valid.
- m_rdata_o, out, DATA_WIDTH: response data, broadcast to all ports.
- s_req_o, out, 1: downstream request.
- s_gnt_i, in, 1: downstream grant.
- s_addr_o, out, ADDR_WIDTH: downstream address.
- s_we_o, out, 1: downstream write enable.
- s_be_o, out, DATA_WIDTH/8: downstream byte enables.
- s_wdata_o, out, DATA_WIDTH: downstream write data.
- s_rvalid_i, in, 1: downstream response valid.
- s_rdata_i, in, DATA_WIDTH: downstream response data.
- outstanding_o, out, $clog2(MAX_OUTSTANDING+1): count of accepted requests not yet answered.
- err_o, out, 1: sticky protocol-error flag.

Function
REQ-003 The block SHALL compute the selected port `sel` combinationally from m_req_i, ARB_MODE, the round-robin pointer `rr_ptr` and the lock state.
REQ-004 In RR mode, selection SHALL be the first requesting port found searching upward from rr_ptr with modulo-NUM_PORTS wrap.
REQ-005 In FIXED mode, selection SHALL be the lowest-index requesting port; rr_ptr is unused.
REQ-006 The block SHALL drive s_req_o = (|m_req_i) & ~fifo_full.
REQ-007 The block SHALL drive s_addr_o, s_we_o, s_be_o and s_wdata_o from the slices of port sel; when s_req_o=0 these outputs are don't-care.
REQ-008 The block SHALL drive m_gnt_o[i] = s_req_o & s_gnt_i & (sel==i); at most one bit is set per cycle.
REQ-009 A handshake (s_req_o & s_gnt_i) SHALL push sel into the routing FIFO and, in RR mode, load rr_ptr with (sel+1) mod NUM_PORTS on the next edge.
REQ-010 While s_req_o=1 and s_gnt_i=0, the block SHALL set a lock register holding sel, so that sel does not change until that port's handshake completes, keeping the OBI address phase stable.
REQ-011 The lock SHALL clear on handshake, or when the locked port deasserts m_req_i; the latter case also sets err_o.
REQ-012 On s_rvalid_i=1 with the FIFO non-empty, the block SHALL assert m_rvalid_o[head] in the same cycle (zero latency) and pop the head on the next edge.
REQ-013 The block SHALL drive m_rdata_o = s_rdata_i at all times.
REQ-014 A FIFO full condition (MAX_OUTSTANDING entries) SHALL force s_req_o=0 and all m_gnt_o=0, with no same-cycle pop bypass, even when s_rvalid_i=1.
REQ-015 A simultaneous push and pop while not full SHALL leave outstanding_o unchanged and keep FIFO order.
REQ-016 s_rvalid_i=1 with the FIFO empty SHALL assert no m_rvalid_o bit, leave the count unchanged and set err_o.
REQ-017 err_o SHALL clear only on reset.
REQ-018 Responses SHALL be delivered in grant order; the downstream slave is in-order.
REQ-019 With NUM_PORTS=1 the block SHALL degenerate to a pass-through plus the outstanding limit.

Reset
REQ-020 While rst_ni=0, the block SHALL hold rr_ptr=0, FIFO empty, lock clear, outstanding_o=0, err_o=0, s_req_o=0, m_gnt_o=0 and m_rvalid_o=0.
REQ-021 Reset asserted mid-transaction SHALL discard all outstanding entries; responses arriving after reset release are treated as in REQ-016.

Verification
REQ-022 Scenario: RR, NUM_PORTS=3, all ports requesting continuously, s_gnt_i=1 -> grants follow the order 0,1,2,0,1,2.
REQ-023 Scenario: FIXED, ports 0 and 2 requesting, s_gnt_i=1 -> port 0 is granted every cycle and port 2 is starved.
REQ-024 Scenario: port 1 requests, s_gnt_i held low for 3 cycles, port 0 raises m_req_i in cycle 2 -> sel stays 1; m_gnt_o=0b010 when s_gnt_i rises.
REQ-025 Scenario: MAX_OUTSTANDING=2, two grants, no rvalid -> outstanding_o=2 and s_req_o=0; one rvalid routes to the first granted port and the next cycle s_req_o=1.
REQ-026 Scenario: grants to ports 2 then 0, then two rvalids with rdata 0xA5A5A5A5 and 0x5A5A5A5A -> m_rvalid_o=0b100 then 0b001 with the matching m_rdata_o.
REQ-027 Scenario: s_rvalid_i pulsed with the FIFO empty -> no m_rvalid_o, err_o=1 until rst_ni=0.
